entropy_pollctl: RTL
====================

// Module: entropy_pollctl
// PURPOSE
//  Controller between the LFSR entropy source and its consumers. Sequences
//  source warm-up (BIST), clocks the source SHIFTS_PER_SAMPLE times per sample,
//  and buffers samples in a small FIFO. Arbitrates the FIFO round-robin
//  between the CPU `mentropy` path and an auxiliary requester (key-gen unit).
// PARAMETERS
//  FIFO_DEPTH        4   sample FIFO entries (power of 2, >=2)
//  BIST_CYCLES       64  warm-up cycles after reset/noise-test exit
//  SHIFTS_PER_SAMPLE 16  source req pulses per captured sample
//  RCT_CUTOFF        4   identical consecutive samples that trigger DEAD
// PORTS
//  g_clk       in   1   global clock
//  g_reset     in   1   asynchronous reset, active-high
//  src_req     out  1   advance entropy source (one shift per cycle high)
//  src_data    in   16  source sample; reflects shifts from prior cycles
//  noise_test  in   1   noise-test mode; source halted
//  cpu_req     in   1   CPU poll request; held until cpu_ack
//  cpu_ack     out  1   one-cycle response strobe
//  cpu_opst    out  2   status, valid with cpu_ack
//  cpu_data    out  16  sample, valid with cpu_ack (0 unless opst=ES16)
//  aux_req/aux_ack/aux_opst/aux_data: as cpu_* for the auxiliary requester
// BEHAVIOUR
//  - opst: BIST=2'b00 ES16=2'b01 WAIT=2'b10 DEAD=2'b11.
//  - Reset (async): state BIST, FIFO empty, all counters 0, src_req=0,
//    acks=0, opst=BIST, data=0, RR pointer favours cpu.
//  - States: BIST -> RUN after BIST_CYCLES cycles (src_req=1 every BIST cycle;
//    output discarded). RUN -> DEAD on health fail (sticky until reset).
//    Any state except DEAD -> BIST when noise_test=1; the warm-up counter
//    restarts on noise_test falling.
//  - RUN draw: starts only if FIFO count + draw-in-flight < FIFO_DEPTH.
//    src_req=1 for SHIFTS_PER_SAMPLE consecutive cycles, then src_data is
//    pushed the following cycle; one sample per SHIFTS_PER_SAMPLE+1 cycles.
//    FIFO full -> no new draw; a started draw always completes.
//  - noise_test=1: src_req forced 0, draw aborted, FIFO flushed.
//  - Response: req sampled at edge N, ack pulses one cycle in N+1 with
//    registered opst/data; at most one grant per cycle; requester drops req
//    after ack; req held in ack cycle is not re-granted until the cycle after.
//  - Arbitration: both pending -> grant the one not granted last; loser is
//    granted next cycle. Non-ES16 responses are arbitrated identically.
//  - Status: BIST state -> BIST; DEAD -> DEAD; RUN + empty -> WAIT;
//    RUN + non-empty -> ES16, pop head.
//  - Same-cycle push+pop: both performed, count unchanged; pop decides on
//    pre-push count (empty + push -> WAIT).
// CONFIGURATION
//  ENTROPY_POLLCTL_HEALTH_EN defined: repetition-count test on each pushed
//   sample; counter increments when sample equals previous pushed sample,
//   else reloads 1; reaching RCT_CUTOFF -> DEAD, FIFO flushed, src_req=0.
//   Counter cleared by reset and when entering BIST.
//  Undefined: no comparator or counter registers; DEAD unreachable.
// STRUCTURE
//  entropy_pkg: opst localparams/enum, ctl state enum {BIST,RUN,DEAD}.
//  Sub-module entropy_pollctl_fifo: sync FIFO, push/pop/flush, count, full/empty.
//  Top holds FSM, draw counter, RR arbiter, response registers, health test.
// TESTING
//  1 reset; cpu_req at cycle 5 -> cpu_ack cycle 6, opst=00, data=0.
//  2 reset, model LFSR from 32'hABCDEF37; cpu_req at cycle 90 -> opst=01,
//    data=model prng[15:0] after 64+16 shifts; src_req high cycles 0..79.
//  3 FIFO holds 2; cpu_req+aux_req same cycle -> cpu ack, then aux ack next
//    cycle, distinct samples in push order; third request on empty -> 10.
//  4 stall requesters 200 cycles -> count=4, src_req stays 0 once full;
//    one pop -> next draw starts the following cycle.
//  5 stub src_data=16'h1234 constant, macro on -> DEAD after 4th push,
//    opst=11 for both; macro off -> opst=01, data=16'h1234.
//  6 noise_test=1 mid-draw -> src_req=0 next cycle, FIFO empty, opst=00;
//    release -> 64 BIST cycles before first draw.

Source files
------------

// File: rtl/entropy_pkg.sv
// Shared types for the entropy poll controller: response status codes,
// controller state encoding and the sample width.
package entropy_pkg;

  localparam int unsigned DATA_W = 16;

  // Response status returned with every ack.
  typedef enum logic [1:0] {
    OPST_BIST = 2'b00,
    OPST_ES16 = 2'b01,
    OPST_WAIT = 2'b10,
    OPST_DEAD = 2'b11
  } opst_e;

  // Controller state. DEAD is sticky until reset.
  typedef enum logic [1:0] {
    CTL_BIST = 2'b00,
    CTL_RUN  = 2'b01,
    CTL_DEAD = 2'b10
  } ctl_state_e;

endpackage

// File: rtl/entropy_pollctl_fifo.sv
// Small synchronous sample FIFO with push, pop and flush. Pop on empty and
// push on full (without a simultaneous pop) are ignored. Flush wins over
// push and pop in the same cycle.
module entropy_pollctl_fifo
  import entropy_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  logic [WIDTH-1:0]        i_data,
  output logic [WIDTH-1:0]        o_data,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Sample storage write port.
  // NOTE: the storage array has no reset; a slot is only read after it has
  // been written, and leaving it unreset lets it map onto plain flops/RAM.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of 2.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/entropy_pollctl.sv
// Entropy poll controller: warms up the LFSR source, draws one sample every
// SHIFTS_PER_SAMPLE+1 cycles into a FIFO and serves the CPU and auxiliary
// requesters round-robin with registered ack/status/data.
// Optional repetition-count health test: define ENTROPY_POLLCTL_HEALTH_EN.
module entropy_pollctl
  import entropy_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned BIST_CYCLES       = 64,
  parameter int unsigned SHIFTS_PER_SAMPLE = 16,
  parameter int unsigned RCT_CUTOFF        = 4
) (
  input  logic              g_clk,
  input  logic              g_reset,
  output logic              src_req,
  input  logic [DATA_W-1:0] src_data,
  input  logic              noise_test,
  input  logic              cpu_req,
  output logic              cpu_ack,
  output logic [1:0]        cpu_opst,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              aux_req,
  output logic              aux_ack,
  output logic [1:0]        aux_opst,
  output logic [DATA_W-1:0] aux_data
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(BIST_CYCLES + 1);
  localparam int unsigned SW = $clog2(SHIFTS_PER_SAMPLE + 1);
  localparam logic [BW-1:0] BIST_LAST  = BW'(BIST_CYCLES - 1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(SHIFTS_PER_SAMPLE - 1);

  ctl_state_e        r_state;
  logic [BW-1:0]     r_bist_cnt;
  logic [SW-1:0]     r_shift_cnt;
  logic              r_drawing;    // src_req phase of a draw
  logic              r_capture;    // capture cycle: src_data is pushed at its end
  logic              r_src_req;
  logic              r_last_aux;   // 1: aux was granted last, cpu wins a tie
  logic              r_cpu_ack;
  logic              r_aux_ack;
  opst_e             r_cpu_opst;
  opst_e             r_aux_opst;
  logic [DATA_W-1:0] r_cpu_data;
  logic [DATA_W-1:0] r_aux_data;

  logic [CW-1:0]     w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [DATA_W-1:0] w_fifo_head;
  logic [CW:0]       w_occupancy;
  logic              w_draw_room;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_health_fail;
  logic              w_cpu_elig;
  logic              w_aux_elig;
  logic              w_grant_cpu;
  logic              w_grant_aux;
  opst_e             w_resp_opst;
  logic [DATA_W-1:0] w_resp_data;

  // Draw pipeline: a sample in capture counts against the FIFO space.
  assign w_occupancy = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_capture};
  assign w_draw_room = ~w_fifo_full & (w_occupancy < (CW+1)'(FIFO_DEPTH));
  assign w_push      = r_capture & (r_state == CTL_RUN) & ~noise_test;
  assign w_flush     = noise_test | w_health_fail;

  // A requester whose ack is on the bus this cycle is not eligible again yet.
  assign w_cpu_elig  = cpu_req & ~r_cpu_ack;
  assign w_aux_elig  = aux_req & ~r_aux_ack;
  assign w_grant_cpu = w_cpu_elig & (~w_aux_elig | r_last_aux);
  assign w_grant_aux = w_aux_elig & ~w_grant_cpu;

  assign w_pop       = (w_grant_cpu | w_grant_aux) & (r_state == CTL_RUN) & ~w_fifo_empty;
  assign w_resp_data = w_pop ? w_fifo_head : '0;

  // Status seen by whichever requester is granted this cycle.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_resp_opst = OPST_BIST;
    unique case (r_state)
      CTL_BIST: w_resp_opst = OPST_BIST;
      CTL_RUN:  w_resp_opst = w_fifo_empty ? OPST_WAIT : OPST_ES16;
      CTL_DEAD: w_resp_opst = OPST_DEAD;
      default:  w_resp_opst = OPST_BIST;
    endcase
  end

`ifdef ENTROPY_POLLCTL_HEALTH_EN
  localparam int unsigned RW = $clog2(RCT_CUTOFF + 1);

  logic [RW-1:0]     r_rct_cnt;
  logic [DATA_W-1:0] r_rct_prev;
  logic [RW-1:0]     w_rct_next;

  assign w_rct_next    = ((r_rct_cnt != '0) && (src_data == r_rct_prev)) ?
                         r_rct_cnt + 1'b1 : RW'(1);
  assign w_health_fail = w_push & (w_rct_next >= RW'(RCT_CUTOFF));

  // Repetition-count test over the stream of pushed samples.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_rct_cnt  <= '0;
      r_rct_prev <= '0;
    end else if (noise_test && (r_state != CTL_DEAD)) begin
      r_rct_cnt  <= '0;
    end else if (w_push) begin
      r_rct_cnt  <= w_rct_next;
      r_rct_prev <= src_data;
    end
  end
`else
  assign w_health_fail = 1'b0;
`endif

  // Controller FSM: warm-up, sample draws and the sticky DEAD state.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state     <= CTL_BIST;
      r_bist_cnt  <= '0;
      r_shift_cnt <= '0;
      r_drawing   <= 1'b0;
      r_capture   <= 1'b0;
      r_src_req   <= 1'b0;
    end else begin
      r_capture <= 1'b0;
      if (noise_test && (r_state != CTL_DEAD)) begin
        r_state     <= CTL_BIST;
        r_bist_cnt  <= '0;
        r_shift_cnt <= '0;
        r_drawing   <= 1'b0;
        r_src_req   <= 1'b0;
      end else begin
        unique case (r_state)
          CTL_BIST: begin
            r_src_req <= 1'b1;
            if (r_src_req) begin
              if (r_bist_cnt == BIST_LAST) begin
                // Last warm-up shift: roll straight into the first draw.
                r_state     <= CTL_RUN;
                r_bist_cnt  <= '0;
                r_drawing   <= 1'b1;
                r_shift_cnt <= '0;
              end else begin
                r_bist_cnt <= r_bist_cnt + 1'b1;
              end
            end
          end
          CTL_RUN: begin
            if (w_health_fail) begin
              r_state   <= CTL_DEAD;
              r_drawing <= 1'b0;
              r_src_req <= 1'b0;
            end else if (r_drawing) begin
              if (r_shift_cnt == SHIFT_LAST) begin
                r_drawing   <= 1'b0;
                r_src_req   <= 1'b0;
                r_capture   <= 1'b1;
                r_shift_cnt <= '0;
              end else begin
                r_shift_cnt <= r_shift_cnt + 1'b1;
              end
            end else if (w_draw_room) begin
              r_drawing <= 1'b1;
              r_src_req <= 1'b1;
            end
          end
          default: begin
            r_drawing <= 1'b0;
            r_src_req <= 1'b0;
          end
        endcase
      end
    end
  end

  // Registered responses and round-robin history.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_cpu_ack  <= 1'b0;
      r_aux_ack  <= 1'b0;
      r_cpu_opst <= OPST_BIST;
      r_aux_opst <= OPST_BIST;
      r_cpu_data <= '0;
      r_aux_data <= '0;
      r_last_aux <= 1'b1;
    end else begin
      r_cpu_ack  <= w_grant_cpu;
      r_aux_ack  <= w_grant_aux;
      r_cpu_opst <= w_grant_cpu ? w_resp_opst : OPST_BIST;
      r_aux_opst <= w_grant_aux ? w_resp_opst : OPST_BIST;
      r_cpu_data <= w_grant_cpu ? w_resp_data : '0;
      r_aux_data <= w_grant_aux ? w_resp_data : '0;
      if (w_grant_cpu) begin
        r_last_aux <= 1'b0;
      end else if (w_grant_aux) begin
        r_last_aux <= 1'b1;
      end
    end
  end

  entropy_pollctl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .i_clk   (g_clk),
    .i_rst   (g_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (src_data),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign src_req  = r_src_req;
  assign cpu_ack  = r_cpu_ack;
  assign cpu_opst = r_cpu_opst;
  assign cpu_data = r_cpu_data;
  assign aux_ack  = r_aux_ack;
  assign aux_opst = r_aux_opst;
  assign aux_data = r_aux_data;

endmodule
